// File: rtl/vc_arb_requester.sv
// Requester-side front end for one port of the round-robin vc_arbiter: FIFO + burst FSM.
// Optional starvation monitor is compiled in when VC_ARB_REQ_STARVE_EN is defined.
module vc_arb_requester #(
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 4,
    parameter int BURST_MAX = 8,
    parameter int WAIT_MAX  = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              domain,
    input  logic              in_val,
    output logic              in_rdy,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              req,
    input  logic              gnt,
    output logic              out_val,
    input  logic              out_rdy,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              starve
);
    localparam int AW = $clog2(DEPTH);
    localparam int BW = $clog2(BURST_MAX + 1);
    localparam logic [BW-1:0] BURST_FULL = BW'(BURST_MAX);
    localparam logic [BW-1:0] BURST_LAST = BW'(BURST_MAX - 1);

    typedef enum logic [1:0] {IDLE, REQ, XFER, REL} state_t;

    state_t            state;
    state_t            state_next;
    logic [DATA_W-1:0] mem_data [DEPTH];
    logic              mem_last [DEPTH];
    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;
    logic              head_last;
    logic              beat_ok;
    logic [BW-1:0]     beat_cnt;

    // The domain input only labels the control state; no logic depends on its value.
    logic unused_domain;
    assign unused_domain = domain;

    // Extra pointer MSB distinguishes full from empty when the index bits match.
    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign in_rdy    = !full;
    assign push      = in_val && in_rdy;
    assign pop       = out_val && out_rdy;
    assign out_data  = mem_data[rd_ptr[AW-1:0]];
    assign head_last = mem_last[rd_ptr[AW-1:0]];
    assign out_last  = head_last || (beat_cnt == BURST_LAST);
    assign beat_ok   = gnt && !empty && out_rdy;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr[AW-1:0]] <= in_data;
            mem_last[wr_ptr[AW-1:0]] <= in_last;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // REL is held while gnt stays high so the arbiter sees req drop and rotates.
    always_comb begin
        state_next = state;
        req        = 1'b0;
        out_val    = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    state_next = REQ;
                end
            end
            REQ: begin
                req = 1'b1;
                if (gnt) begin
                    state_next = XFER;
                end
            end
            XFER: begin
                req     = 1'b1;
                out_val = gnt && !empty;
                if (!gnt) begin
                    state_next = REQ;
                end else if (beat_ok && out_last) begin
                    state_next = REL;
                end else if (empty && !in_val) begin
                    state_next = REL;
                end
            end
            REL: begin
                if (!gnt) begin
                    state_next = empty ? IDLE : REQ;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || state == REQ) begin
            beat_cnt <= '0;
        end else if (state == XFER && pop && beat_cnt != BURST_FULL) begin
            beat_cnt <= beat_cnt + BW'(1);
        end
    end

`ifdef VC_ARB_REQ_STARVE_EN
    localparam int WW = $clog2(WAIT_MAX + 1);
    localparam logic [WW-1:0] WAIT_SAT = WW'(WAIT_MAX);

    logic [WW-1:0] wait_cnt;

    // wait_cnt counts REQ cycles including the current one, so starve lines up with cycle WAIT_MAX.
    always_ff @(posedge clk) begin
        if (rst || state_next != REQ) begin
            wait_cnt <= '0;
        end else if (state != REQ) begin
            wait_cnt <= WW'(1);
        end else if (wait_cnt != WAIT_SAT) begin
            wait_cnt <= wait_cnt + WW'(1);
        end
    end

    assign starve = (wait_cnt == WAIT_SAT);
`else
    localparam int unused_wait_max = WAIT_MAX;
    assign starve = 1'b0;
`endif

    assert property (@(posedge clk) disable iff (rst) out_val |-> (req && gnt));

endmodule
